// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: program counter, single-outstanding imem request/grant/response
// handshake, registered IF/ID output backed by a one-entry skid buffer, redirect with drop.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        stall,
  output logic        id_valid,
  output logic [31:0] id_instruction,
  output logic [31:0] id_pc
);

  localparam logic [31:0] NOP     = 32'h0000_0013;
  localparam logic [31:0] PC_STEP = 32'd4;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d, addr_q, addr_d;
  logic        req_q, req_d;
  logic        drop_q, drop_d;
  logic        out_valid_q, out_valid_d;
  logic [31:0] out_instr_q, out_instr_d, out_pc_q, out_pc_d;
  logic        skid_valid_q, skid_valid_d;
  logic [31:0] skid_instr_q, skid_instr_d, skid_pc_q, skid_pc_d;

  logic        rsp_v, load, consume, out_free;
  logic [31:0] tgt;

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    addr_d       = addr_q;
    drop_d       = drop_q;
    out_valid_d  = out_valid_q;
    out_instr_d  = out_instr_q;
    out_pc_d     = out_pc_q;
    skid_valid_d = skid_valid_q;
    skid_instr_d = skid_instr_q;
    skid_pc_d    = skid_pc_q;

    rsp_v    = (state_q == S_WAIT) && imem_rvalid;
    load     = rsp_v && !drop_q;
    consume  = out_valid_q && !stall;
    out_free = !out_valid_q || !stall;
    tgt      = redirect_pc & ~32'd3;

    // Fetch sequencing; pc only advances on a grant whose response will be kept.
    case (state_q)
      S_IDLE: begin
        if (!skid_valid_q) begin
          state_d = S_REQ;
          addr_d  = pc_q;
        end
      end
      S_REQ: begin
        if (imem_gnt) begin
          state_d = S_WAIT;
          if (!drop_q) pc_d = pc_q + PC_STEP;
        end
      end
      S_WAIT: begin
        if (imem_rvalid) begin
          drop_d = 1'b0;
          if (drop_q || out_free) begin
            state_d = S_REQ;
            addr_d  = pc_q;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Output register and skid; skid is only ever full while fetch is parked in IDLE.
    if (consume) begin
      if (skid_valid_q) begin
        out_instr_d  = skid_instr_q;
        out_pc_d     = skid_pc_q;
        skid_valid_d = 1'b0;
      end else if (load) begin
        out_instr_d = imem_rdata;
        out_pc_d    = addr_q;
      end else begin
        out_valid_d = 1'b0;
      end
    end else if (!out_valid_q) begin
      if (load) begin
        out_valid_d = 1'b1;
        out_instr_d = imem_rdata;
        out_pc_d    = addr_q;
      end
    end else if (load) begin
      skid_valid_d = 1'b1;
      skid_instr_d = imem_rdata;
      skid_pc_d    = addr_q;
    end

    // Redirect overrides everything; an ungranted request keeps its address.
    if (redirect_valid) begin
      pc_d         = tgt;
      out_valid_d  = 1'b0;
      skid_valid_d = 1'b0;
      case (state_q)
        S_IDLE: begin
          state_d = S_REQ;
          addr_d  = tgt;
        end
        S_REQ:  drop_d = 1'b1;
        S_WAIT: begin
          if (imem_rvalid) begin
            drop_d  = 1'b0;
            state_d = S_REQ;
            addr_d  = tgt;
          end else begin
            drop_d = 1'b1;
          end
        end
        default: drop_d = 1'b0;
      endcase
    end

    req_d = (state_d == S_REQ);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      pc_q         <= RESET_PC;
      addr_q       <= RESET_PC;
      req_q        <= 1'b0;
      drop_q       <= 1'b0;
      out_valid_q  <= 1'b0;
      out_instr_q  <= NOP;
      out_pc_q     <= RESET_PC;
      skid_valid_q <= 1'b0;
      skid_instr_q <= NOP;
      skid_pc_q    <= RESET_PC;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      addr_q       <= addr_d;
      req_q        <= req_d;
      drop_q       <= drop_d;
      out_valid_q  <= out_valid_d;
      out_instr_q  <= out_instr_d;
      out_pc_q     <= out_pc_d;
      skid_valid_q <= skid_valid_d;
      skid_instr_q <= skid_instr_d;
      skid_pc_q    <= skid_pc_d;
    end
  end

  assign imem_req       = req_q;
  assign imem_addr      = addr_q;
  assign id_valid       = out_valid_q;
  assign id_instruction = out_instr_q;
  assign id_pc          = out_pc_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: behavioural instruction memory, directed scenarios,
// and a scoreboard monitor that checks every word the decode side accepts.
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt = 1'b0;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = 32'h0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        stall = 1'b0;
  logic        id_valid;
  logic [31:0] id_instruction;
  logic [31:0] id_pc;

  instr_fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_gnt       (imem_gnt),
    .imem_rvalid    (imem_rvalid),
    .imem_rdata     (imem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .stall          (stall),
    .id_valid       (id_valid),
    .id_instruction (id_instruction),
    .id_pc          (id_pc)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] ins;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;
  int   n_chk  = 0;
  int   n_pass = 0;

  // Memory knobs: one-shot grant delay, grant-to-rvalid latency, data generation.
  int          gnt_delay  = 0;
  int          dly_cnt    = 0;
  int          rvalid_lat = 1;
  int          lat_cnt    = 0;
  int          gen        = 0;
  bit          pend       = 1'b0;
  logic [31:0] pend_data  = 32'h0;

  function automatic logic [31:0] mem_word(input logic [31:0] a, input int g);
    logic [31:0] base;
    base = (a == 32'h0) ? 32'h0040_00EF : {a[15:0], 16'h0013};
    return (g != 0) ? (base ^ 32'hFFFF_0000) : base;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
  endtask

  task automatic pushx(input logic [31:0] pc);
    exp_t e;
    e.pc  = pc;
    e.ins = mem_word(pc, gen);
    q.push_back(e);
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  always begin
    @(posedge clk);
    #1;
    imem_gnt    = 1'b0;
    imem_rvalid = 1'b0;
    if (pend) begin
      if (lat_cnt <= 1) begin
        imem_rvalid = 1'b1;
        imem_rdata  = pend_data;
        pend        = 1'b0;
      end else begin
        lat_cnt--;
      end
    end else if (imem_req) begin
      if (dly_cnt >= gnt_delay) begin
        imem_gnt  = 1'b1;
        pend      = 1'b1;
        pend_data = mem_word(imem_addr, gen);
        lat_cnt   = rvalid_lat;
        dly_cnt   = 0;
        gnt_delay = 0;
      end else begin
        dly_cnt++;
      end
    end else begin
      dly_cnt = 0;
    end
  end

  // Scoreboard monitor: a word is accepted when id_valid && !stall.
  logic        prev_req = 1'b0;
  logic        prev_gnt = 1'b0;
  logic [31:0] prev_addr = 32'h0;
  always @(negedge clk) begin
    if (!rst) begin
      if (id_valid && !stall) begin
        if (q.size() == 0) begin
          n_chk++;
          $display("FAIL unexpected_word: got pc %08h ins %08h expected none at %0t",
                   id_pc, id_instruction, $time);
        end else begin
          mon_e = q.pop_front();
          chk("id_pc", id_pc, mon_e.pc);
          chk("id_instruction", id_instruction, mon_e.ins);
        end
      end
      if (prev_req && !prev_gnt && imem_req) chk("addr_stable", imem_addr, prev_addr);
    end
    prev_req  = imem_req && !rst;
    prev_gnt  = imem_gnt;
    prev_addr = imem_addr;
  end

  task automatic do_reset(input int lat);
    rst            = 1'b1;
    stall          = 1'b0;
    redirect_valid = 1'b0;
    cyc(2);
    q.delete();
    rvalid_lat = lat;
    gnt_delay  = 0;
    rst        = 1'b0;
    chk("rst_id_valid", 32'(id_valid), 32'h0);
    chk("rst_id_instr", id_instruction, 32'h0000_0013);
    chk("rst_id_pc", id_pc, 32'h0);
    chk("rst_imem_req", 32'(imem_req), 32'h0);
    chk("rst_imem_addr", imem_addr, 32'h0);
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() != 0 && n < 200) begin
      cyc(1);
      n++;
    end
    chk("drain_empty", 32'(q.size()), 32'h0);
    stall = 1'b1;
    cyc(4);
  endtask

  initial begin
    // Reset, first fetch, delayed grant on the second request.
    do_reset(1);
    pushx(32'h0); pushx(32'h4); pushx(32'h8); pushx(32'hC);
    cyc(1); chk("c1_req", 32'(imem_req), 32'h1); chk("c1_addr", imem_addr, 32'h0);
    gnt_delay = 2;
    cyc(1); chk("c2_req", 32'(imem_req), 32'h0);
    cyc(1);
    chk("c3_valid", 32'(id_valid), 32'h1);
    chk("c3_pc", id_pc, 32'h0);
    chk("c3_instr", id_instruction, 32'h0040_00EF);
    chk("c3_req", 32'(imem_req), 32'h1);
    chk("c3_addr", imem_addr, 32'h4);
    cyc(1); chk("c4_req", 32'(imem_req), 32'h1); chk("c4_addr", imem_addr, 32'h4);
    cyc(1); chk("c5_req", 32'(imem_req), 32'h1); chk("c5_addr", imem_addr, 32'h4);
    drain();

    // Stall for six cycles: output holds 0x4, 0x8 parks in skid, fetch stops.
    do_reset(1);
    pushx(32'h0); pushx(32'h4); pushx(32'h8); pushx(32'hC);
    cyc(3); chk("st_c3_valid", 32'(id_valid), 32'h1);
    cyc(1); chk("st_c4_valid", 32'(id_valid), 32'h0);
    stall = 1'b1;
    for (int i = 5; i <= 9; i++) begin
      cyc(1);
      chk("st_hold_valid", 32'(id_valid), 32'h1);
      chk("st_hold_pc", id_pc, 32'h4);
      if (i >= 7) chk("st_no_req", 32'(imem_req), 32'h0);
    end
    cyc(1); chk("st_c10_pc", id_pc, 32'h4);
    stall = 1'b0;
    cyc(1); chk("st_c11_valid", 32'(id_valid), 32'h1); chk("st_c11_pc", id_pc, 32'h8);
    drain();

    // Redirect to 0x401 while waiting on a response.
    do_reset(2);
    pushx(32'h0); pushx(32'h400); pushx(32'h404);
    cyc(5); chk("rw_c5_req", 32'(imem_req), 32'h0);
    redirect_valid = 1'b1; redirect_pc = 32'h0000_0401;
    cyc(1); redirect_valid = 1'b0;
    chk("rw_c6_valid", 32'(id_valid), 32'h0);
    chk("rw_c6_req", 32'(imem_req), 32'h0);
    cyc(1); chk("rw_c7_req", 32'(imem_req), 32'h1); chk("rw_c7_addr", imem_addr, 32'h400);
    drain();

    // Redirect coincident with rvalid while stalled with a held word.
    do_reset(1);
    pushx(32'h400); pushx(32'h404);
    cyc(3); chk("rc_c3_pc", id_pc, 32'h0);
    stall = 1'b1;
    cyc(1); chk("rc_c4_valid", 32'(id_valid), 32'h1);
    redirect_valid = 1'b1; redirect_pc = 32'h0000_0402;
    cyc(1); redirect_valid = 1'b0;
    chk("rc_c5_valid", 32'(id_valid), 32'h0);
    chk("rc_c5_req", 32'(imem_req), 32'h1);
    chk("rc_c5_addr", imem_addr, 32'h400);
    stall = 1'b0;
    cyc(1); chk("rc_c6_valid", 32'(id_valid), 32'h0);
    drain();

    // Redirect while the request is still waiting for a grant.
    do_reset(1);
    pushx(32'h800); pushx(32'h804);
    gnt_delay = 3;
    cyc(2);
    redirect_valid = 1'b1; redirect_pc = 32'h0000_0800;
    cyc(1); redirect_valid = 1'b0;
    chk("rq_c3_req", 32'(imem_req), 32'h1);
    chk("rq_c3_addr", imem_addr, 32'h0);
    cyc(3); chk("rq_c6_req", 32'(imem_req), 32'h1); chk("rq_c6_addr", imem_addr, 32'h800);
    drain();

    // Reset while waiting; the stale response arrives after release.
    do_reset(4);
    cyc(1); chk("rs_c1_req", 32'(imem_req), 32'h1);
    rvalid_lat = 1;
    cyc(1); chk("rs_c2_req", 32'(imem_req), 32'h0);
    rst = 1'b1;
    gen = 1;
    #1;
    chk("rs_mid_valid", 32'(id_valid), 32'h0);
    chk("rs_mid_req", 32'(imem_req), 32'h0);
    chk("rs_mid_instr", id_instruction, 32'h0000_0013);
    chk("rs_mid_addr", imem_addr, 32'h0);
    cyc(1);
    rst = 1'b0;
    pushx(32'h0); pushx(32'h4);
    cyc(1); chk("rs_c4_req", 32'(imem_req), 32'h1); chk("rs_c4_addr", imem_addr, 32'h0);
    for (int i = 5; i <= 7; i++) begin
      cyc(1);
      chk("rs_no_stale", 32'(id_valid), 32'h0);
    end
    drain();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
